// File: rtl/seq_det_pkg.sv
// -----------------------------------------------------------------------------
// seq_det_pkg
// Shared definitions for the parametrised serial sequence detector:
//   - default pattern length and match-counter width
//   - default pattern constant (zero-extended or truncated to W at the top)
//   - fill-state encoding used by the window-fill FSM
// No ports; imported by seq_detector_param and seq_match_counter.
// -----------------------------------------------------------------------------
package seq_det_pkg;

    localparam int unsigned SEQ_DEF_W     = 4;
    localparam int unsigned SEQ_DEF_CNT_W = 8;

    localparam logic [3:0] SEQ_DEF_PATTERN = 4'b1010;

    // EMPTY   : no bits of the current window held
    // FILLING : some, but fewer than W-1, bits held
    // ARMED   : W-1 bits held, the next accepted bit can complete a match
    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        ARMED   = 2'd2
    } fill_state_t;

endpackage : seq_det_pkg

// File: rtl/seq_match_counter.sv
// -----------------------------------------------------------------------------
// seq_match_counter
// Saturating event counter. A clear has priority, but an increment in the
// same cycle still counts, so clear+increment leaves the count at 1.
//
// Ports:
//   clk    in  1      rising-edge clock
//   reset  in  1      asynchronous active-low reset
//   clr    in  1      synchronous clear
//   inc    in  1      count one event
//   count  out CNT_W  current count, saturates at all-ones
//   sat    out 1      registered flag: count is all-ones
// -----------------------------------------------------------------------------
module seq_match_counter
    import seq_det_pkg::*;
#(
    parameter int unsigned CNT_W = SEQ_DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             sat
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] count_p1;
    logic [CNT_W-1:0] count_d;
    logic             sat_p1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    always_comb begin
        count_d = count_p1;
        if (clr) begin
            count_d = inc ? CNT_W'(1) : '0;
        end else if (inc) begin
            count_d = sat_inc(count_p1);
        end
    end

    // ---- stage p1: count register and all-ones flag ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_p1 <= '0;
            sat_p1   <= 1'b0;
        end else begin
            count_p1 <= count_d;
            sat_p1   <= (count_d == CNT_MAX);
        end
    end

    assign count = count_p1;
    assign sat   = sat_p1;

endmodule : seq_match_counter

// File: rtl/seq_detector_param.sv
// -----------------------------------------------------------------------------
// seq_detector_param
// Serial sequence detector with a runtime-programmable W-bit pattern.
// Watches a qualified bit stream and pulses z one cycle after the accepted
// bit that completes a match of the last W accepted bits. Supports
// overlapping and non-overlapping detection and counts matches.
//
// Ports:
//   clk          in  1      rising-edge clock
//   reset        in  1      asynchronous active-low reset
//   x            in  1      serial data bit
//   x_valid      in  1      x is accepted on this edge
//   cfg_load     in  1      load pattern/overlap and restart detection
//   cfg_pattern  in  W      new pattern, bit W-1 is the earliest in time
//   cfg_overlap  in  1      1 = overlapping, 0 = non-overlapping
//   clr_count    in  1      synchronous clear of the match counter
//   z            out 1      registered one-cycle match pulse
//   match_count  out CNT_W  saturating match count
//   count_sat    out 1      match_count is all-ones
//   armed        out 1      W-1 bits held, next accepted bit may match
// -----------------------------------------------------------------------------
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int unsigned  W           = SEQ_DEF_W,
    parameter logic [W-1:0] DEF_PATTERN = W'(SEQ_DEF_PATTERN),
    parameter int unsigned  CNT_W       = SEQ_DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             x,
    input  logic             x_valid,
    input  logic             cfg_load,
    input  logic [W-1:0]     cfg_pattern,
    input  logic             cfg_overlap,
    input  logic             clr_count,
    output logic             z,
    output logic [CNT_W-1:0] match_count,
    output logic             count_sat,
    output logic             armed
);

    // fill never exceeds W-1, so clog2(W) bits always suffice (W >= 2)
    localparam int unsigned       FILL_W   = $clog2(W);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(W - 1);

    logic [W-2:0]      hist_p1,    hist_d;
    logic [FILL_W-1:0] fill_p1,    fill_d;
    fill_state_t       state_p1,   state_d;
    logic [W-1:0]      pattern_p1, pattern_d;
    logic              overlap_p1, overlap_d;
    logic              z_p1;
    logic              armed_p1;

    logic              vld_p0;
    logic [W-1:0]      window_p0;
    logic              match_p0;

    // ---- stage p0: qualify the incoming bit and compare the window ----
    // A configuration load discards any bit presented in the same cycle.
    assign vld_p0    = x_valid & ~cfg_load;
    assign window_p0 = {hist_p1, x};
    assign match_p0  = vld_p0 && (fill_p1 == FILL_MAX) && (window_p0 == pattern_p1);

    always_comb begin
        hist_d    = hist_p1;
        fill_d    = fill_p1;
        state_d   = state_p1;
        pattern_d = pattern_p1;
        overlap_d = overlap_p1;

        if (cfg_load) begin
            hist_d    = '0;
            fill_d    = '0;
            state_d   = EMPTY;
            pattern_d = cfg_pattern;
            overlap_d = cfg_overlap;
        end else if (vld_p0) begin
            hist_d = window_p0[W-2:0];
            unique case (state_p1)
                EMPTY, FILLING: begin
                    fill_d  = fill_p1 + FILL_W'(1);
                    state_d = (fill_d == FILL_MAX) ? ARMED : FILLING;
                end
                ARMED: begin
                    // Non-overlap discards the matched window entirely; in
                    // overlap mode the newest W-1 bits stay usable.
                    if (match_p0 && !overlap_p1) begin
                        fill_d  = '0;
                        state_d = EMPTY;
                    end
                end
                default: begin
                    fill_d  = '0;
                    state_d = EMPTY;
                end
            endcase
        end
    end

    // ---- stage p1: window state, configuration and output registers ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist_p1    <= '0;
            fill_p1    <= '0;
            state_p1   <= EMPTY;
            pattern_p1 <= DEF_PATTERN;
            overlap_p1 <= 1'b1;
            z_p1       <= 1'b0;
            armed_p1   <= 1'b0;
        end else begin
            hist_p1    <= hist_d;
            fill_p1    <= fill_d;
            state_p1   <= state_d;
            pattern_p1 <= pattern_d;
            overlap_p1 <= overlap_d;
            z_p1       <= match_p0;
            armed_p1   <= (state_d == ARMED);
        end
    end

    seq_match_counter #(
        .CNT_W (CNT_W)
    ) u_match_counter (
        .clk   (clk),
        .reset (reset),
        .clr   (clr_count),
        .inc   (match_p0),
        .count (match_count),
        .sat   (count_sat)
    );

    assign z     = z_p1;
    assign armed = armed_p1;

endmodule : seq_detector_param

// File: tb/tb_seq_detector_param.sv
// -----------------------------------------------------------------------------
// tb_seq_detector_param
// Directed bench for seq_detector_param: a default instance (W=4, CNT_W=8)
// and a small instance (W=2, CNT_W=3) for counter saturation.
// -----------------------------------------------------------------------------
module tb_seq_detector_param;

    logic       clk;
    logic       reset;

    logic       x, x_valid, cfg_load, cfg_overlap, clr_count;
    logic [3:0] cfg_pattern;
    logic       z, count_sat, armed;
    logic [7:0] match_count;

    logic       x_b, x_valid_b, cfg_load_b, cfg_overlap_b, clr_count_b;
    logic [1:0] cfg_pattern_b;
    logic       z_b, count_sat_b, armed_b;
    logic [2:0] match_count_b;

    int n_checks = 0;
    int n_errors = 0;

    seq_detector_param u_dut (
        .clk         (clk),
        .reset       (reset),
        .x           (x),
        .x_valid     (x_valid),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_overlap (cfg_overlap),
        .clr_count   (clr_count),
        .z           (z),
        .match_count (match_count),
        .count_sat   (count_sat),
        .armed       (armed)
    );

    seq_detector_param #(
        .W     (2),
        .CNT_W (3)
    ) u_dut_b (
        .clk         (clk),
        .reset       (reset),
        .x           (x_b),
        .x_valid     (x_valid_b),
        .cfg_load    (cfg_load_b),
        .cfg_pattern (cfg_pattern_b),
        .cfg_overlap (cfg_overlap_b),
        .clr_count   (clr_count_b),
        .z           (z_b),
        .match_count (match_count_b),
        .count_sat   (count_sat_b),
        .armed       (armed_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic b, input logic exp_z, input string tag);
        x_valid = 1'b1;
        x       = b;
        tick();
        x_valid = 1'b0;
        check(tag, z, exp_z);
    endtask

    task automatic gap(input logic junk, input logic exp_z, input string tag);
        x_valid = 1'b0;
        x       = junk;
        tick();
        check(tag, z, exp_z);
    endtask

    task automatic load(input logic [3:0] pat, input logic ov);
        cfg_load    = 1'b1;
        cfg_pattern = pat;
        cfg_overlap = ov;
        tick();
        cfg_load    = 1'b0;
        cfg_pattern = 4'hF;
        cfg_overlap = ~ov;
    endtask

    bit t1_x[6] = '{1, 0, 1, 0, 1, 0};
    bit t1_z[6] = '{0, 0, 0, 1, 0, 1};
    bit t1_a[6] = '{0, 0, 1, 1, 1, 1};
    bit t2_x[8] = '{1, 0, 1, 0, 1, 0, 1, 0};
    bit t2_z[8] = '{0, 0, 0, 1, 0, 0, 0, 1};
    bit t2_a[8] = '{0, 0, 1, 0, 0, 0, 1, 0};
    int t4_c[10] = '{0, 1, 2, 3, 4, 5, 6, 7, 7, 1};
    bit t4_s[10] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 0};

    initial begin
        reset = 1'b0;
        x = 1'b0; x_valid = 1'b0; cfg_load = 1'b0; cfg_pattern = 4'h0;
        cfg_overlap = 1'b0; clr_count = 1'b0;
        x_b = 1'b0; x_valid_b = 1'b0; cfg_load_b = 1'b0; cfg_pattern_b = 2'b00;
        cfg_overlap_b = 1'b0; clr_count_b = 1'b0;

        repeat (2) tick();
        check("rst z", z, 0);
        check("rst count", match_count, 0);
        check("rst sat", count_sat, 0);
        check("rst armed", armed, 0);
        reset = 1'b1;
        tick();

        // default config: 1010, overlapping
        for (int i = 0; i < 6; i++) begin
            feed(t1_x[i], t1_z[i], $sformatf("t1 z bit%0d", i + 1));
            check($sformatf("t1 armed bit%0d", i + 1), armed, t1_a[i]);
        end
        check("t1 count", match_count, 2);
        check("t1 sat", count_sat, 0);

        // non-overlapping 1010
        load(4'b1010, 1'b0);
        check("t2 armed after load", armed, 0);
        check("t2 load keeps count", match_count, 2);
        clr_count = 1'b1;
        tick();
        clr_count = 1'b0;
        check("t2 clr count", match_count, 0);
        for (int i = 0; i < 8; i++) begin
            feed(t2_x[i], t2_z[i], $sformatf("t2 z bit%0d", i + 1));
            check($sformatf("t2 armed bit%0d", i + 1), armed, t2_a[i]);
        end
        check("t2 count", match_count, 2);

        // valid gaps, junk x values while x_valid is low
        load(4'b1010, 1'b1);
        feed(1'b1, 1'b0, "t3 b1");
        gap(1'b1, 1'b0, "t3 gap1");
        feed(1'b0, 1'b0, "t3 b2");
        gap(1'b1, 1'b0, "t3 gap2");
        gap(1'b1, 1'b0, "t3 gap3");
        feed(1'b1, 1'b0, "t3 b3");
        feed(1'b0, 1'b1, "t3 b4 match");
        gap(1'b1, 1'b0, "t3 z one cycle");
        check("t3 count", match_count, 3);

        // asynchronous reset mid-stream restores the default pattern
        load(4'b0110, 1'b1);
        feed(1'b1, 1'b0, "t5 b1");
        feed(1'b0, 1'b0, "t5 b2");
        feed(1'b1, 1'b0, "t5 b3");
        check("t5 armed before reset", armed, 1);
        reset = 1'b0;
        #2;
        check("t5 async z", z, 0);
        check("t5 async count", match_count, 0);
        check("t5 async sat", count_sat, 0);
        check("t5 async armed", armed, 0);
        tick();
        reset = 1'b1;
        feed(1'b0, 1'b0, "t5 stale window");
        check("t5 armed after one bit", armed, 0);
        feed(1'b1, 1'b0, "t5 c1");
        feed(1'b0, 1'b0, "t5 c2");
        feed(1'b1, 1'b0, "t5 c3");
        feed(1'b0, 1'b1, "t5 c4 default pattern");
        check("t5 count", match_count, 1);

        // cfg_load with a simultaneous valid bit drops that bit
        cfg_load    = 1'b1;
        cfg_pattern = 4'b0110;
        cfg_overlap = 1'b1;
        x_valid     = 1'b1;
        x           = 1'b0;
        tick();
        cfg_load = 1'b0;
        x_valid  = 1'b0;
        check("t6 load cycle z", z, 0);
        check("t6 armed after load", armed, 0);
        feed(1'b1, 1'b0, "t6 b1");
        feed(1'b1, 1'b0, "t6 b2");
        feed(1'b0, 1'b0, "t6 b3 dropped bit");
        check("t6 armed", armed, 1);
        feed(1'b0, 1'b0, "t6 b4");
        feed(1'b1, 1'b0, "t6 b5");
        feed(1'b1, 1'b0, "t6 b6");
        feed(1'b0, 1'b1, "t6 b7 match");
        check("t6 count", match_count, 2);

        // W=2, CNT_W=3: pattern 11 overlapping, saturation and clear+match
        cfg_load_b    = 1'b1;
        cfg_pattern_b = 2'b11;
        cfg_overlap_b = 1'b1;
        tick();
        cfg_load_b    = 1'b0;
        cfg_pattern_b = 2'b00;
        for (int i = 0; i < 10; i++) begin
            x_valid_b   = 1'b1;
            x_b         = 1'b1;
            clr_count_b = (i == 9);
            tick();
            x_valid_b   = 1'b0;
            clr_count_b = 1'b0;
            check($sformatf("t4 z bit%0d", i + 1), z_b, (i == 0) ? 0 : 1);
            check($sformatf("t4 count bit%0d", i + 1), match_count_b, t4_c[i]);
            check($sformatf("t4 sat bit%0d", i + 1), count_sat_b, t4_s[i]);
        end
        check("t4 armed", armed_b, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1);
    end

endmodule : tb_seq_detector_param

// File: doc/seq_detector_param.md
# seq_detector_param

Parametrised serial sequence detector, the successor to the fixed 4-bit `seq_detector`. It watches a qualified serial bit stream and pulses `z` each time the last `W` accepted bits equal a runtime-programmable pattern. Overlapping and non-overlapping detection are both supported, and a saturating counter records the number of matches. It sits between a serial front-end and status/interrupt logic.

## Interface

**Parameters**
- `W`, default 4: pattern length in bits, legal range 2..32.
- `DEF_PATTERN`, default `4'b1010` (zero-extended to `W`): pattern loaded at reset.
- `CNT_W`, default 8: width of the match counter, legal range 2..16.

**Ports**
- `clk`, in, 1: single clock; all state changes on the rising edge.
- `reset`, in, 1: asynchronous, active-low; asserting it (0) clears state immediately.
- `x`, in, 1: serial data bit.
- `x_valid`, in, 1: `x` is accepted on a rising edge only when this is 1.
- `cfg_load`, in, 1: load `cfg_pattern` and `cfg_overlap`, then restart detection.
- `cfg_pattern`, in, `W`: new pattern; bit `W-1` is the first bit expected in time.
- `cfg_overlap`, in, 1: 1 = overlapping detection, 0 = non-overlapping.
- `clr_count`, in, 1: synchronous clear of the match counter.
- `z`, out, 1: registered one-cycle match pulse.
- `match_count`, out, `CNT_W`: number of matches, saturating.
- `count_sat`, out, 1: `match_count` has reached all-ones.
- `armed`, out, 1: at least `W-1` bits of the current window are held, so the next accepted bit can complete a match.

## Operation

- Internal state:
  - `hist[W-2:0]`: shift history; the newest bit is in the LSB.
  - `fill`: 0..W-1, saturating.
  - Pattern register and overlap register.
- The candidate window is `{hist, x}`.
- A match is `x_valid & ~cfg_load & (fill == W-1) & ({hist, x} == pattern)`.
- Accepted bit (`x_valid`=1, `cfg_load`=0):
  - `hist` shifts in `x`.
  - `fill` increments, saturating at `W-1`.
- On a match:
  - In overlap mode, `fill` stays at `W-1`.
  - In non-overlap mode, `fill` returns to 0, so the bits of the matched window are never reused.
- Fill states:
  - EMPTY (`fill`=0): leaves to FILLING on an accepted bit.
  - FILLING (0<`fill`<`W-1`): moves to ARMED when `fill` reaches `W-1`.
  - ARMED (`fill`=`W-1`): drives `armed`=1; a non-overlap match returns it to EMPTY.
  - `cfg_load` or reset returns to EMPTY from any state.
- `cfg_load`:
  - Has priority over `x_valid`; a bit presented in the same cycle is discarded.
  - Clears `hist` and `fill`.
  - Does not touch `match_count`.
- Counter:
  - Increments by 1 on each match and saturates at 2^CNT_W−1.
  - `count_sat` is the registered "all-ones" flag.
  - `clr_count` and a match in the same cycle give `match_count`=1.
- Reset values:
  - `hist`=0, `fill`=0, pattern=`DEF_PATTERN`, overlap=1.
  - `z`=0, `match_count`=0, `count_sat`=0, `armed`=0.

## Timing

- Latency: `z` is high during the cycle after the edge that accepts the completing bit, and for exactly one cycle.
- Back-to-back matches:
  - In overlap mode with a periodic pattern, `z` can pulse on consecutive valid bits, e.g. pattern 1111 on a stream of 1s gives a pulse on every bit after the 4th.
  - In non-overlap mode, successive pulses are at least `W` accepted bits apart.
- `match_count` updates on the same edge that raises `z`.
- `armed` is registered and reflects `fill` after the edge.
- Gaps with `x_valid`=0 freeze all state; `z` drops after its one cycle.
- Reset asserted mid-stream: all registers clear asynchronously and the partial window is lost. After deassertion, a full `W` fresh bits are needed before a match.
- `cfg_pattern` and `cfg_overlap` are sampled only when `cfg_load`=1.

## Structure

- Package `seq_det_pkg`:
  - Default `W` and `CNT_W`.
  - Default pattern constant.
  - Fill-state encoding constants EMPTY, FILLING, ARMED.
- Sub-module `seq_match_counter`: saturating counter with clear-priority-then-increment semantics.
- Top level holds the history, fill, compare and config registers.

## Test plan

- Reset, default config (1010, overlap), feed valid bits 1,0,1,0,1,0 -> `z` pulses after the 4th and 6th bits, `match_count`=2, `armed`=1 from after the 3rd bit.
- `cfg_load` with pattern 1010 and `cfg_overlap`=0, feed 1,0,1,0,1,0,1,0 -> `z` after the 4th and 8th bits only, `match_count`=2.
- Valid gaps: feed 1,(gap),0,(gap),(gap),1,0 -> single `z` pulse after the final 0; values of `x` during gaps are ignored.
- `CNT_W`=3, pattern 11 overlap, 10 valid 1s -> `match_count`=7 and `count_sat`=1 after the 8th bit; `clr_count` pulsed on the edge of the 10th bit's match -> `match_count`=1, `count_sat`=0.
- Feed 1,0,1, then pulse `reset` low, then feed 0 -> no `z`, all outputs 0, pattern back to 1010; a subsequent 1,0,1,0 -> `z` once.
- `cfg_load` (pattern 0110) asserted together with `x_valid` and `x`=0, followed by 1,1,0 -> no `z` (the simultaneous bit is dropped); a further 0,1,1,0 -> `z` once.
